// File: rtl/program_loader.sv
// program_loader
//
// Fills the processor's program memory from a byte stream before execution.
// Bytes arrive over a valid/ready handshake and are packed little-endian into
// one instruction per BYTES_PER_INSTR bytes. Each finished word is written to
// consecutive program-memory addresses, starting at a latched base address.
// The CPU is held stalled from the start of a load until the last word is
// written.
//
// Ports
//   in_clk, in_rst         clock (rising edge), synchronous active-high reset
//   in_start               begin a load (only honoured while idle)
//   in_base_add, in_count  first write address / word count (0 = 2^ADDR_W),
//                          both latched on start
//   in_byte, in_byte_valid stream data and its valid flag
//   out_byte_ready         a byte is accepted this cycle if valid is high
//   out_wr_en/_add/_data   program-memory write port, one strobe per word
//   out_cpu_hold, out_busy high while a load is in progress
//   out_done               one-cycle pulse after the final write
//   out_err                sticky flag: a last byte carried nonzero padding
module program_loader #(
  parameter int INSTR_W         = 29,
  parameter int ADDR_W          = 8,
  parameter int BYTES_PER_INSTR = 4
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_start,
  input  logic [ADDR_W-1:0]  in_base_add,
  input  logic [ADDR_W-1:0]  in_count,
  input  logic [7:0]         in_byte,
  input  logic               in_byte_valid,
  output logic               out_byte_ready,
  output logic               out_wr_en,
  output logic [ADDR_W-1:0]  out_wr_add,
  output logic [INSTR_W-1:0] out_wr_data,
  output logic               out_cpu_hold,
  output logic               out_busy,
  output logic               out_done,
  output logic               out_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int IDX_W = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_INSTR - 1);
  // First bit position of the last byte that falls outside the instruction.
  localparam int PAD_LSB = INSTR_W - 8 * (BYTES_PER_INSTR - 1);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  // One bit wider than the address so a count of 0 can stand for 2^ADDR_W.
  logic [ADDR_W:0]    rem_q,   rem_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [INSTR_W-1:0] word_q,  word_d;
  logic               err_q,   err_d;

  logic accept;
  logic pad_bad;

  assign accept  = (state_q == S_RECV) && in_byte_valid;
  assign pad_bad = (in_byte >> PAD_LSB) != 8'd0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          addr_d  = in_base_add;
          // Zero count maps to a full memory: top bit set, low bits zero.
          rem_d   = {(in_count == '0), in_count};
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (accept) begin
          // Drop the byte into its little-endian lane; bits beyond INSTR_W
          // simply have no destination.
          for (int i = 0; i < INSTR_W; i++) begin
            if (idx_q == IDX_W'(i / 8)) word_d[i] = in_byte[i % 8];
          end
          if (idx_q == LAST_IDX) begin
            if (pad_bad) err_d = 1'b1;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        idx_d   = '0;
        state_d = (rem_q == (ADDR_W + 1)'(1)) ? S_DONE : S_RECV;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign out_byte_ready = (state_q == S_RECV);
  assign out_wr_en      = (state_q == S_WRITE);
  assign out_done       = (state_q == S_DONE);
  assign out_busy       = (state_q != S_IDLE);
  assign out_cpu_hold   = out_busy;
  // Address and data are only meaningful with out_wr_en; outside WRITE they
  // just show the working registers.
  assign out_wr_add     = addr_q;
  assign out_wr_data    = word_q;
  assign out_err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_add, count;
  logic [7:0]  byte_d;
  logic        byte_valid;
  logic        byte_ready, wr_en, cpu_hold, busy, done, err;
  logic [7:0]  wr_add;
  logic [28:0] wr_data;

  program_loader dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .in_start      (start),
    .in_base_add   (base_add),
    .in_count      (count),
    .in_byte       (byte_d),
    .in_byte_valid (byte_valid),
    .out_byte_ready(byte_ready),
    .out_wr_en     (wr_en),
    .out_wr_add    (wr_add),
    .out_wr_data   (wr_data),
    .out_cpu_hold  (cpu_hold),
    .out_busy      (busy),
    .out_done      (done),
    .out_err       (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scoreboard: {address, word} of every write the reference model predicts.
  logic [36:0] wr_q[$];
  int          done_pend = 0;
  logic        exp_err   = 1'b0;
  int          hold_len  = 0;
  int          last_hold = 0;

  // Reference model state: where the next word lands and how many remain.
  logic [7:0]  m_addr;
  int          m_rem;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [36:0] e;
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {wr_add, wr_data}, 64'h0);
        if ({wr_add, wr_data} == '0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got write at %0h, expected none", wr_add);
        end
      end else begin
        e = wr_q.pop_front();
        chk("wr_add", wr_add, e[36:29]);
        chk("wr_data", wr_data, e[28:0]);
      end
    end
    if (done) begin
      chk("done_expected", (done_pend > 0), 1);
      if (done_pend > 0) done_pend--;
      chk("done_after_last_write", wr_q.size(), 0);
    end
    chk("err", err, exp_err);
    if (cpu_hold) hold_len++;
    else if (hold_len != 0) begin
      last_hold = hold_len;
      hold_len  = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    wr_q.delete();
    done_pend = 0;
    exp_err   = 1'b0;
    chk("reset_outputs",
        {byte_ready, wr_en, wr_add, wr_data, cpu_hold, busy, done, err}, 64'h0);
  endtask

  task automatic do_start(logic [7:0] b, logic [7:0] c);
    start    = 1'b1;
    base_add = b;
    count    = c;
    cyc();
    start    = 1'b0;
    // Changes after start must not matter.
    base_add = 8'($urandom());
    count    = 8'($urandom());
    m_addr   = b;
    m_rem    = (c == 0) ? 256 : int'(c);
    exp_err  = 1'b0;
    chk("ready_after_start", byte_ready, 1);
  endtask

  // Offer one byte until accepted; with stall the valid flag is randomized
  // but the byte itself is held steady.
  task automatic send_byte(logic [7:0] b, bit stall, output bit ok);
    bit acc;
    ok     = 1'b0;
    byte_d = b;
    for (int g = 0; g < 200; g++) begin
      byte_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = byte_ready && byte_valid;
      cyc();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("byte_accept_timeout", 0, 1);
  endtask

  // Sends nbytes of a word; a full word updates the reference model.
  task automatic send_word(logic [31:0] w, bit stall, int nbytes);
    bit ok;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(w[8*i +: 8], stall, ok);
      if (!ok) return;
    end
    if (nbytes == 4) begin
      wr_q.push_back({m_addr, w[28:0]});
      if (w[31:29] != 3'b000) exp_err = 1'b1;
      m_addr = m_addr + 8'd1;
      m_rem--;
      if (m_rem == 0) done_pend++;
    end
  endtask

  task automatic wait_idle(int exp_hold);
    for (int g = 0; g < 40 && busy; g++) cyc();
    byte_valid = 1'b0;
    chk("idle_reached", busy, 0);
    @(negedge clk);
    #1;
    chk("writes_drained", wr_q.size(), 0);
    chk("done_seen", done_pend, 0);
    if (exp_hold > 0) chk("hold_cycles", last_hold, exp_hold);
  endtask

  function automatic logic [31:0] rnd_word();
    return $urandom() & 32'h1FFF_FFFF;
  endfunction

  task automatic load(logic [7:0] b, logic [7:0] c, bit stall, bit poke_start);
    int k;
    k = (c == 0) ? 256 : int'(c);
    do_start(b, c);
    for (int i = 0; i < k; i++) begin
      if (poke_start && i == 1) begin
        // Start pulse while loading: must not disturb address or count.
        byte_valid = 1'b0;
        start      = 1'b1;
        base_add   = 8'h77;
        count      = 8'h05;
        cyc();
        start      = 1'b0;
      end
      send_word(rnd_word(), stall, 4);
    end
    wait_idle(stall || poke_start ? 0 : 5 * k + 1);
  endtask

  initial begin
    bit ok;
    rst = 1'b0; start = 1'b0; base_add = '0; count = '0;
    byte_d = '0; byte_valid = 1'b0;

    // Reset, then stay idle.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_outputs", {byte_ready, wr_en, cpu_hold, busy, done}, 0);
    end

    // Single directed word.
    do_start(8'h10, 8'd1);
    send_word(32'h0802_0001, 1'b0, 4);
    wait_idle(6);

    // Stalled stream, two words from address 0.
    load(8'h00, 8'd2, 1'b1, 1'b0);

    // Address wrap.
    load(8'hFE, 8'd3, 1'b0, 1'b0);

    // Full memory load.
    load(8'h00, 8'd0, 1'b0, 1'b0);

    // Padding error: top byte 0xE5 keeps its low 5 bits, err sticks.
    do_start(8'h40, 8'd1);
    send_word(32'hE5_33_22_11, 1'b0, 4);
    wait_idle(6);
    for (int i = 0; i < 5; i++) cyc();
    chk("err_sticky", err, 1);
    load(8'h41, 8'd2, 1'b0, 1'b0);
    chk("err_cleared_by_start", err, 0);

    // Ignored start mid-load, then reset partway through word 2.
    load(8'h20, 8'd3, 1'b0, 1'b1);
    do_start(8'h30, 8'd2);
    send_word(rnd_word(), 1'b0, 4);
    byte_valid = 1'b0;
    start = 1'b1; base_add = 8'h99;
    cyc();
    start = 1'b0;
    send_word(rnd_word(), 1'b0, 2);
    byte_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) cyc();
    chk("post_abort_idle", {busy, wr_en}, 0);
    load(8'h50, 8'd2, 1'b0, 1'b0);

    // Random loads.
    for (int t = 0; t < 6; t++)
      load(8'($urandom()), 8'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'b0);

    chk("final_queue_empty", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
